// File: rtl/bit_parser_stream.sv
// Streaming word-to-symbol splitter: WORD_W-bit words in on valid/ready,
// SYM_W-bit symbols out one per cycle, with order select, frame-end tag and symbol count.
module bit_parser_stream #(
  parameter int WORD_W    = 32,
  parameter int SYM_W     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 32,
  localparam int NSYM     = WORD_W / SYM_W,
  localparam int IDX_W    = ($clog2(NSYM) < 1) ? 1 : $clog2(NSYM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [SYM_W-1:0]  m_sym,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last,
  output logic [CNT_W-1:0]  sym_count
);

  generate
    if ((WORD_W % SYM_W) != 0 || NSYM < 2) begin : g_bad_params
      $error("bit_parser_stream: WORD_W must be a multiple of SYM_W with at least 2 symbols");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic              r_last;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_idx_end;
  logic              w_cons;
  logic              w_acc;
  logic [WORD_W-1:0] w_shift;

  // The held word is shifted so the outgoing symbol always sits at a fixed slice.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign m_sym   = r_word[WORD_W-1 -: SYM_W];
      assign w_shift = {r_word[WORD_W-SYM_W-1:0], {SYM_W{1'b0}}};
    end else begin : g_lsb
      assign m_sym   = r_word[SYM_W-1:0];
      assign w_shift = {{SYM_W{1'b0}}, r_word[WORD_W-1:SYM_W]};
    end
  endgenerate

  assign m_valid   = (r_state == S_EMIT);
  assign m_idx     = r_idx;
  assign m_last    = r_last && w_idx_end;
  assign sym_count = r_cnt;

  assign w_idx_end = (r_idx == IDX_W'(NSYM - 1));
  assign w_cons    = m_valid && m_ready && !clear;
  assign s_ready   = !clear && ((r_state == S_IDLE) || (m_valid && m_ready && w_idx_end));
  assign w_acc     = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_cons) r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc) begin
        r_state <= S_EMIT;
        r_word  <= s_data;
        r_last  <= s_last;
        r_idx   <= '0;
      end else if (w_cons) begin
        if (w_idx_end) begin
          r_state <= S_IDLE;
          r_last  <= 1'b0;
          r_idx   <= '0;
          r_word  <= w_shift;
        end else begin
          r_idx  <= r_idx + IDX_W'(1);
          r_word <= w_shift;
        end
      end
    end
  end

endmodule
